// File: rtl/hdmi_pll_supervisor_if.sv
// Signal bundle between the HDMI PLL supervisor and the PLL / video reset domain.
// The supervisor side uses the master modport; the environment side uses slave.
interface hdmi_pll_supervisor_if;
   logic       pll_lock;
   logic       pll_rst;
   logic       video_rst;
   logic       ready;
   logic [1:0] state;
   logic [7:0] relock_cnt;
   logic       timeout_seen;

   modport master (
      input  pll_lock,
      output pll_rst, video_rst, ready, state, relock_cnt, timeout_seen
   );

   modport slave (
      output pll_lock,
      input  pll_rst, video_rst, ready, state, relock_cnt, timeout_seen
   );
endinterface

// File: rtl/hdmi_pll_supervisor.sv
// HDMI PLL lock/reset supervisor: sequences pll_rst, waits for stable lock, releases video_rst.
// Optional macro HDMI_PLL_SUP_GLITCH_FILTER_EN tolerates short lock dropouts while running.
module hdmi_pll_supervisor #(
   parameter int unsigned RST_CYCLES    = 64,
   parameter int unsigned LOCK_TIMEOUT  = 500000,
   parameter int unsigned SETTLE_CYCLES = 1024,
   parameter int unsigned GLITCH_CYCLES = 4,
   parameter int unsigned CNT_W         = 20
) (
   input  logic                   clk,
   input  logic                   reset,
   hdmi_pll_supervisor_if.master  sup
);

   typedef enum logic [1:0] {
      S_RST       = 2'd0,
      S_WAIT_LOCK = 2'd1,
      S_SETTLE    = 2'd2,
      S_RUN       = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

   state_t           st;
   logic [CNT_W-1:0] cnt;
   logic             lock_p0;
   logic             lock_s;
   logic             pll_rst_r;
   logic             video_rst_r;
   logic             ready_r;
   logic             timeout_r;
   logic [7:0]       relock_r;
   logic             leave_run;

`ifdef HDMI_PLL_SUP_GLITCH_FILTER_EN
   localparam logic [CNT_W-1:0] GLITCH_LAST = CNT_W'(GLITCH_CYCLES - 1);
   logic [CNT_W-1:0] low_cnt;

   // Leave RUN on the GLITCH_CYCLES-th consecutive low sample.
   assign leave_run = !lock_s && (low_cnt == GLITCH_LAST);
`else
   assign leave_run = !lock_s;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         st          <= S_RST;
         cnt         <= '0;
         lock_p0     <= 1'b0;
         lock_s      <= 1'b0;
         pll_rst_r   <= 1'b1;
         video_rst_r <= 1'b1;
         ready_r     <= 1'b0;
         timeout_r   <= 1'b0;
         relock_r    <= '0;
`ifdef HDMI_PLL_SUP_GLITCH_FILTER_EN
         low_cnt     <= '0;
`endif
      end else begin
         lock_p0 <= sup.pll_lock;
         lock_s  <= lock_p0;
         // Outputs are updated together with st so they track the next state.
         case (st)
            S_RST: begin
               if (cnt == RST_LAST) begin
                  st        <= S_WAIT_LOCK;
                  cnt       <= '0;
                  pll_rst_r <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_WAIT_LOCK: begin
               if (lock_s) begin
                  st  <= S_SETTLE;
                  cnt <= '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  st        <= S_RST;
                  cnt       <= '0;
                  pll_rst_r <= 1'b1;
                  timeout_r <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_SETTLE: begin
               if (!lock_s) begin
                  st  <= S_WAIT_LOCK;
                  cnt <= '0;
               end else if (cnt == SETTLE_LAST) begin
                  st          <= S_RUN;
                  video_rst_r <= 1'b0;
                  ready_r     <= 1'b1;
`ifdef HDMI_PLL_SUP_GLITCH_FILTER_EN
                  low_cnt     <= '0;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RUN: begin
`ifdef HDMI_PLL_SUP_GLITCH_FILTER_EN
               if (lock_s)          low_cnt <= '0;
               else if (!leave_run) low_cnt <= low_cnt + 1'b1;
`endif
               if (leave_run) begin
                  st          <= S_RST;
                  cnt         <= '0;
                  pll_rst_r   <= 1'b1;
                  video_rst_r <= 1'b1;
                  ready_r     <= 1'b0;
                  if (relock_r != 8'hFF) relock_r <= relock_r + 8'd1;
               end
            end
         endcase
      end
   end

   assign sup.state        = st;
   assign sup.pll_rst      = pll_rst_r;
   assign sup.video_rst    = video_rst_r;
   assign sup.ready        = ready_r;
   assign sup.relock_cnt   = relock_r;
   assign sup.timeout_seen = timeout_r;

endmodule

// File: tb/tb_hdmi_pll_supervisor.sv
// Directed bench for hdmi_pll_supervisor with RST=4, TIMEOUT=32, SETTLE=8, GLITCH=3.
// Edge k means the k-th rising clk edge after reset is released; checks sample at the following negedge.
`timescale 1ns/1ps
module tb_hdmi_pll_supervisor;
`ifdef HDMI_PLL_SUP_GLITCH_FILTER_EN
   localparam int DROP = 3;
`else
   localparam int DROP = 1;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   bound_fail = 0;
   int   n;
   int   es;
   logic ep;

   hdmi_pll_supervisor_if sif();

   hdmi_pll_supervisor #(
      .RST_CYCLES(4), .LOCK_TIMEOUT(32), .SETTLE_CYCLES(8),
      .GLITCH_CYCLES(3), .CNT_W(20)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .sup   (sif)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input int cyc);
      repeat (cyc) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic start(input logic lk);
      reset = 1'b1;
      sif.pll_lock = lk;
      step(2);
      reset = 1'b0;
   endtask

   initial begin
      sif.pll_lock = 1'b1;
      step(3);
      chk("rst_state", sif.state, 0);
      chk("rst_pll_rst", sif.pll_rst, 1);
      chk("rst_video_rst", sif.video_rst, 1);
      chk("rst_ready", sif.ready, 0);
      chk("rst_relock", sif.relock_cnt, 0);
      chk("rst_timeout", sif.timeout_seen, 0);

      // Nominal bring-up with lock tied high.
      reset = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         step(1);
         es = (k < 4) ? 0 : (k == 4) ? 1 : (k < 13) ? 2 : 3;
         chk("bringup_state", sif.state, es);
         chk("bringup_pll_rst", sif.pll_rst, k < 4);
         chk("bringup_ready", sif.ready, k >= 13);
         chk("bringup_video_rst", sif.video_rst, k < 13);
      end
      chk("bringup_relock", sif.relock_cnt, 0);
      chk("bringup_timeout", sif.timeout_seen, 0);
      step(2);

`ifdef HDMI_PLL_SUP_GLITCH_FILTER_EN
      // Two-cycle dropout must be ignored.
      sif.pll_lock = 1'b0;
      step(2);
      sif.pll_lock = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step(1);
         chk("glitch2_ready", sif.ready, 1);
         chk("glitch2_state", sif.state, 3);
      end
      chk("glitch2_relock", sif.relock_cnt, 0);
`endif

      // Lock loss in RUN: RST is entered DROP+2 edges after the drop starts.
      sif.pll_lock = 1'b0;
      step(DROP);
      sif.pll_lock = 1'b1;
      step(1);
      chk("loss_still_run", sif.state, 3);
      step(1);
      chk("loss_state", sif.state, 0);
      chk("loss_pll_rst", sif.pll_rst, 1);
      chk("loss_video_rst", sif.video_rst, 1);
      chk("loss_ready", sif.ready, 0);
      chk("loss_relock", sif.relock_cnt, 1);
      step(12);
      chk("rerun_not_ready", sif.ready, 0);
      chk("rerun_state_settle", sif.state, 2);
      step(1);
      chk("rerun_ready", sif.ready, 1);
      chk("rerun_state_run", sif.state, 3);

      // 300 more relocks: counter saturates at 255.
      for (int i = 0; i < 300; i++) begin
         sif.pll_lock = 1'b0;
         step(DROP);
         sif.pll_lock = 1'b1;
         n = 0;
         while (sif.ready !== 1'b0 && n < 10) begin step(1); n++; end
         if (sif.ready !== 1'b0) bound_fail++;
         n = 0;
         while (sif.ready !== 1'b1 && n < 30) begin step(1); n++; end
         if (sif.ready !== 1'b1) bound_fail++;
         if (i == 252) chk("sat_relock_254", sif.relock_cnt, 254);
      end
      chk("sat_bounds", bound_fail, 0);
      chk("sat_relock_255", sif.relock_cnt, 255);

      // Reset while in SETTLE clears everything, including relock_cnt.
      sif.pll_lock = 1'b0;
      step(DROP);
      sif.pll_lock = 1'b1;
      n = 0;
      while (sif.state !== 2'd2 && n < 40) begin step(1); n++; end
      chk("midsettle_reach", sif.state, 2);
      reset = 1'b1;
      step(1);
      chk("midsettle_state", sif.state, 0);
      chk("midsettle_pll_rst", sif.pll_rst, 1);
      chk("midsettle_video_rst", sif.video_rst, 1);
      chk("midsettle_ready", sif.ready, 0);
      chk("midsettle_relock", sif.relock_cnt, 0);
      chk("midsettle_timeout", sif.timeout_seen, 0);

      // Timeout retry: lock low for 100 cycles then high.
      start(1'b0);
      for (int k = 1; k <= 111; k++) begin
         step(1);
         if (k <= 102) begin
            ep = (k % 36) < 4;
            es = ep ? 0 : 1;
         end else begin
            ep = 1'b0;
            es = (k < 111) ? 2 : 3;
         end
         chk("tmo_state", sif.state, es);
         chk("tmo_pll_rst", sif.pll_rst, ep);
         chk("tmo_seen", sif.timeout_seen, k >= 36);
         chk("tmo_ready", sif.ready, k >= 111);
         if (k == 100) sif.pll_lock = 1'b1;
      end
      chk("tmo_relock", sif.relock_cnt, 0);

      // Settle abort: one-cycle lock drop during SETTLE restarts the wait.
      start(1'b1);
      for (int k = 1; k <= 19; k++) begin
         step(1);
         if (k == 1) chk("abort_timeout_cleared", sif.timeout_seen, 0);
         es = (k < 4) ? 0 : (k == 4) ? 1 : (k < 10) ? 2 : (k == 10) ? 1 : (k < 19) ? 2 : 3;
         chk("abort_state", sif.state, es);
         chk("abort_ready", sif.ready, k >= 19);
         if (k == 7) sif.pll_lock = 1'b0;
         if (k == 8) sif.pll_lock = 1'b1;
      end

      // Lock falls exactly on the SETTLE terminal count: WAIT_LOCK wins over RUN.
      start(1'b1);
      step(10);
      sif.pll_lock = 1'b0;
      step(1);
      sif.pll_lock = 1'b1;
      step(1);
      chk("tc_settle_before", sif.state, 2);
      step(1);
      chk("tc_settle_to_wait", sif.state, 1);
      chk("tc_settle_ready", sif.ready, 0);
      step(1);
      chk("tc_settle_resettle", sif.state, 2);
      step(8);
      chk("tc_settle_run", sif.state, 3);
      chk("tc_settle_ready_late", sif.ready, 1);

      // Lock rises on the WAIT_LOCK timeout cycle: SETTLE wins over RST.
      start(1'b0);
      step(33);
      sif.pll_lock = 1'b1;
      step(2);
      chk("tc_wait_before", sif.state, 1);
      step(1);
      chk("tc_wait_to_settle", sif.state, 2);
      chk("tc_wait_no_timeout", sif.timeout_seen, 0);
      chk("tc_wait_pll_rst", sif.pll_rst, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
